// File: rtl/psg_register_file.sv
// SN76489-style latch/data write decoder and register bank for the PSG.
// Holds tone periods, attenuations and noise control, and models the READY busy window.
module psg_register_file #(
  parameter int BUSY_CYCLES = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       we,
  input  logic [7:0] data,
  output logic       ready,
  output logic [9:0] tone0_compare,
  output logic [9:0] tone1_compare,
  output logic [9:0] tone2_compare,
  output logic [3:0] atten0,
  output logic [3:0] atten1,
  output logic [3:0] atten2,
  output logic [3:0] atten3,
  output logic [2:0] noise_ctrl,
  output logic       noise_reset
);

  localparam int CW = (BUSY_CYCLES > 0) ? $clog2(BUSY_CYCLES + 1) : 1;
  localparam logic [CW-1:0] BUSY_LOAD = CW'(BUSY_CYCLES);

  logic [CW-1:0] busy_cnt;
  logic [2:0]    latch_ptr;
  logic [2:0]    sel;
  logic          is_latch;
  logic          accept;

  // ready is a pure decode of the registered busy counter.
  assign ready    = (busy_cnt == '0);
  assign accept   = we & ready;
  assign is_latch = data[7];
  // A latch byte names its own target; a data byte goes to the latched register.
  assign sel      = is_latch ? data[6:4] : latch_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_cnt      <= '0;
      latch_ptr     <= 3'b000;
      tone0_compare <= '0;
      tone1_compare <= '0;
      tone2_compare <= '0;
      atten0        <= 4'hF;
      atten1        <= 4'hF;
      atten2        <= 4'hF;
      atten3        <= 4'hF;
      noise_ctrl    <= '0;
      noise_reset   <= 1'b0;
    end else begin
      noise_reset <= 1'b0;
      if (busy_cnt != '0) busy_cnt <= busy_cnt - 1'b1;
      if (accept) begin
        busy_cnt <= BUSY_LOAD;
        if (is_latch) latch_ptr <= data[6:4];
        case (sel)
          3'b000: begin
            if (is_latch) tone0_compare[3:0] <= data[3:0];
            else          tone0_compare[9:4] <= data[5:0];
          end
          3'b010: begin
            if (is_latch) tone1_compare[3:0] <= data[3:0];
            else          tone1_compare[9:4] <= data[5:0];
          end
          3'b100: begin
            if (is_latch) tone2_compare[3:0] <= data[3:0];
            else          tone2_compare[9:4] <= data[5:0];
          end
          3'b110: begin
            noise_ctrl  <= data[2:0];
            noise_reset <= 1'b1;
          end
          3'b001:  atten0 <= data[3:0];
          3'b011:  atten1 <= data[3:0];
          3'b101:  atten2 <= data[3:0];
          default: atten3 <= data[3:0];
        endcase
      end
    end
  end

endmodule

// File: tb/tb_psg_register_file.sv
// Directed bench for psg_register_file: one instance with no busy window, one with 32 busy cycles.
module tb_psg_register_file;

  logic       clk = 1'b0;
  logic       reset;
  logic       we_f, we_s;
  logic [7:0] data_f, data_s;

  logic       ready_f, ready_s;
  logic [9:0] t0_f, t1_f, t2_f, t0_s, t1_s, t2_s;
  logic [3:0] a0_f, a1_f, a2_f, a3_f, a0_s, a1_s, a2_s, a3_s;
  logic [2:0] nc_f, nc_s;
  logic       nr_f, nr_s;

  int checks   = 0;
  int failures = 0;
  logic [9:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  psg_register_file #(.BUSY_CYCLES(0)) u_fast (
    .clk(clk), .reset(reset), .we(we_f), .data(data_f), .ready(ready_f),
    .tone0_compare(t0_f), .tone1_compare(t1_f), .tone2_compare(t2_f),
    .atten0(a0_f), .atten1(a1_f), .atten2(a2_f), .atten3(a3_f),
    .noise_ctrl(nc_f), .noise_reset(nr_f)
  );

  psg_register_file #(.BUSY_CYCLES(32)) u_slow (
    .clk(clk), .reset(reset), .we(we_s), .data(data_s), .ready(ready_s),
    .tone0_compare(t0_s), .tone1_compare(t1_s), .tone2_compare(t2_s),
    .atten0(a0_s), .atten1(a1_s), .atten2(a2_s), .atten3(a3_s),
    .noise_ctrl(nc_s), .noise_reset(nr_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks: drive on negedge, return on the negedge after the sampling edge
  task automatic write_f(input logic [7:0] b);
    @(negedge clk);
    we_f = 1'b1; data_f = b;
    @(negedge clk);
    we_f = 1'b0;
  endtask

  task automatic write_s(input logic [7:0] b);
    @(negedge clk);
    we_s = 1'b1; data_s = b;
    @(negedge clk);
    we_s = 1'b0;
  endtask

  task automatic wait_ready_s();
    int n = 0;
    while (!ready_s && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("wait_ready_s", {31'b0, ready_s}, 32'd1);
  endtask

  initial begin
    int low_cnt;
    reset = 1'b1;
    we_f = 1'b0; we_s = 1'b0; data_f = '0; data_s = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // reset state
    check("rst_ready", {31'b0, ready_f}, 32'd1);
    check("rst_tones", {2'b0, t0_f, t1_f, t2_f}, 32'd0);
    check("rst_atten", {16'b0, a0_f, a1_f, a2_f, a3_f}, 32'hFFFF);
    check("rst_noise", {28'b0, nc_f, nr_f}, 32'd0);
    check("rst_ready_s", {31'b0, ready_s}, 32'd1);
    check("rst_atten_s", {16'b0, a0_s, a1_s, a2_s, a3_s}, 32'hFFFF);

    // tone0 latch/data, low nibble kept across data byte
    write_f(8'h8E);
    check("t0_latch", {22'b0, t0_f}, 32'h00E);
    exp_q.push_back(10'h0FE);
    exp_q.push_back(10'h0AE);
    write_f(8'h0F);
    check("t0_data1", {22'b0, t0_f}, {22'b0, exp_q.pop_front()});
    write_f(8'h0A);
    check("t0_data2", {22'b0, t0_f}, {22'b0, exp_q.pop_front()});
    check("t0_ready", {31'b0, ready_f}, 32'd1);

    // attenuation ch1
    write_f(8'hBF);
    check("a1_latch", {28'b0, a1_f}, 32'hF);
    write_f(8'h03);
    check("a1_data", {28'b0, a1_f}, 32'h3);
    check("a_others", {20'b0, a0_f, a2_f, a3_f}, 32'hFFF);
    check("t0_kept", {22'b0, t0_f}, 32'h0AE);

    // noise control with one-cycle pulses
    write_f(8'hE5);
    check("nc_latch", {29'b0, nc_f}, 32'h5);
    check("nr_pulse1", {31'b0, nr_f}, 32'd1);
    @(negedge clk);
    check("nr_drop1", {31'b0, nr_f}, 32'd0);
    write_f(8'h02);
    check("nc_data", {29'b0, nc_f}, 32'h2);
    check("nr_pulse2", {31'b0, nr_f}, 32'd1);
    @(negedge clk);
    check("nr_drop2", {31'b0, nr_f}, 32'd0);

    // back-to-back writes with we held high
    @(negedge clk);
    we_f = 1'b1; data_f = 8'h81;
    @(negedge clk);
    data_f = 8'h05;
    check("b2b_first", {22'b0, t0_f}, 32'h0A1);
    @(negedge clk);
    we_f = 1'b0;
    check("b2b_second", {22'b0, t0_f}, 32'h051);

    // busy window: C3 latches tone2 low nibble
    write_s(8'hC3);
    check("t2_latch", {22'b0, t2_s}, 32'h003);
    check("busy_low", {31'b0, ready_s}, 32'd0);
    we_s = 1'b1; data_s = 8'h9F;
    low_cnt = 0;
    while (!ready_s && low_cnt < 100) begin
      low_cnt++;
      @(negedge clk);
    end
    check("busy_len", low_cnt, 32'd32);
    check("drop_a0", {28'b0, a0_s}, 32'hF);
    @(negedge clk);
    we_s = 1'b0;
    check("acc_busy", {31'b0, ready_s}, 32'd0);
    check("acc_a0", {28'b0, a0_s}, 32'hF);
    check("acc_t2", {22'b0, t2_s}, 32'h003);
    wait_ready_s();
    write_s(8'h07);
    check("ptr_a0", {28'b0, a0_s}, 32'h7);
    check("ptr_t2", {22'b0, t2_s}, 32'h003);

    // reset in the middle of a busy window
    wait_ready_s();
    write_s(8'hD0);
    check("a2_set", {28'b0, a2_s}, 32'h0);
    repeat (4) @(negedge clk);
    check("mid_busy", {31'b0, ready_s}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_ready", {31'b0, ready_s}, 32'd1);
    check("rst_mid_a2", {28'b0, a2_s}, 32'hF);
    check("rst_mid_t2", {22'b0, t2_s}, 32'h000);
    write_s(8'h3F);
    check("rst_ptr_t0", {22'b0, t0_s}, 32'h3F0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/psg_register_file.md
# psg_register_file

Bus-facing write decoder and register bank for the SN76489-compatible PSG. It accepts byte writes in the SN76489 latch/data format and holds the three 10-bit tone period values, four 4-bit attenuation values and the 3-bit noise control. Its outputs feed the tone generators' `compare` inputs, the noise generator and the attenuator/mixer stage directly. It also models the chip's READY busy window after each accepted write.

## Interface

- `BUSY_CYCLES`, default 32: clock cycles `ready` stays low after an accepted write; 0 = always ready.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `we` in 1: write strobe; sampled each rising edge.
- `data` in 8: write byte.
- `ready` out 1: high = a write will be accepted this cycle.
- `tone0_compare`, `tone1_compare`, `tone2_compare` out 10 each: tone period registers.
- `atten0`, `atten1`, `atten2`, `atten3` out 4 each: attenuation for tone0–2 and noise; 0 = loudest, F = off.
- `noise_ctrl` out 3: bit2 = feedback (white/periodic), bits1:0 = shift-rate select.
- `noise_reset` out 1: one-cycle pulse on every accepted write that targets the noise control register.

## Operation

- A write is accepted on a rising edge where `we`=1 and `ready`=1. Writes with `ready`=0 are dropped entirely: no register change, no pulse, busy window not extended.
- Latch byte (`data[7]`=1):
  - `data[6:5]` selects the channel and `data[4]` the type (0 = tone/noise, 1 = attenuation). Both are stored as the 3-bit latched-register pointer.
  - Tone ch0–2, type 0: `toneN_compare[3:0]` <= `data[3:0]`. Bits 9:4 unchanged.
  - Ch3, type 0: `noise_ctrl` <= `data[2:0]`; `data[3]` ignored; `noise_reset` pulses.
  - Any channel, type 1: `attenN` <= `data[3:0]`.
- Data byte (`data[7]`=0): applied to the currently latched register; the pointer is unchanged.
  - Tone: `toneN_compare[9:4]` <= `data[5:0]`. Bits 3:0 unchanged.
  - Attenuation: `attenN` <= `data[3:0]`.
  - Noise: `noise_ctrl` <= `data[2:0]`; `noise_reset` pulses.
  - `data[6]` ignored.
- Busy counter:
  - An accepted write loads `BUSY_CYCLES`. The counter decrements each cycle while nonzero.
  - `ready` = (counter == 0).
  - Counter width is clog2(`BUSY_CYCLES`+1), minimum 1.
- Reset values:
  - tone compares 0 (the tone stage treats 0 as a period of 1024).
  - all `atten` F (silent); `noise_ctrl` 0; latched pointer = ch0 tone.
  - busy counter 0, so `ready`=1; `noise_reset`=0.
- Reset asserted mid busy window clears the counter: `ready`=1 on the first cycle after the reset edge.
- `we` held high for several cycles is one write per cycle while `ready`=1. With `BUSY_CYCLES`=0, back-to-back bytes are all accepted.

## Timing

- All outputs are registered.
- A write accepted at edge N is visible on the register outputs from edge N onward, i.e. during cycle N+1. Latency is 1 cycle.
- `noise_reset` is high for exactly the cycle following edge N and low thereafter, unless another noise write is accepted at edge N+1 (only possible when `BUSY_CYCLES`=0).
- `ready` goes low during cycle N+1 and stays low for exactly `BUSY_CYCLES` cycles. It is high again at the edge N+`BUSY_CYCLES`, so the next write can be accepted there.
- Reset has priority over a simultaneous write: the write is discarded.

## Test plan

- Reset, then check outputs: `ready`=1, all compares 000, all atten F, `noise_ctrl`=0, `noise_reset`=0.
- `BUSY_CYCLES`=0; write 8'h8E then 8'h0F -> `tone0_compare`=0xFE after the second write; write 8'h0A -> 0xAE (low nibble kept).
- Write 8'hBF then data 8'h03 -> `atten1`=F then 3; `atten0`, `atten2` and `atten3` stay F.
- Write 8'hE5 -> `noise_ctrl`=5 with `noise_reset` high for exactly one cycle; data 8'h02 -> `noise_ctrl`=2 with a second one-cycle pulse.
- `BUSY_CYCLES`=32; write 8'hC3 -> `ready` low for 32 cycles; a write of 8'h9F during that window is ignored (`atten0` stays F); the same write is accepted on the first cycle `ready`=1 (`atten0`=F unchanged, `tone2_compare`=003 from the first write).
- Assert `reset` 5 cycles into a busy window after writing 8'hD0 -> `ready`=1 the next cycle, `atten2`=F, latched pointer back to ch0 tone (a following data 8'h3F sets `tone0_compare`=0x3F0).
